// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter in front of a register-file write port.
// Writes to index 0 are accepted but never reach wr_en; they are counted
// on a saturating drop counter instead.
module regfile_wb_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wb_stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [1:0]                grant_id,
  output logic [7:0]                drop_cnt
);

  localparam int unsigned PTR_W = 2;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [1:0]        grant_q, grant_d;
  logic [7:0]        drop_q, drop_d;

  logic              found;
  logic [PTR_W-1:0]  sel;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // First valid requester searching upward from ptr+1 with wrap-around.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      int unsigned j;
      j = 32'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req_valid[PTR_W'(j)]) begin
        found = 1'b1;
        sel   = PTR_W'(j);
      end
    end
  end

  // Acceptance is suppressed by stall and by reset.
  always_comb begin
    xfer      = found && !wb_stall && !reset;
    req_ready = xfer ? (NUM_REQ'(1) << sel) : '0;
    sel_addr  = req_addr[32'(sel)*ADDR_W +: ADDR_W];
    sel_data  = req_data[32'(sel)*DATA_W +: DATA_W];
  end

  // Next-state for pointer, write port and drop counter.
  always_comb begin
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    grant_d   = grant_q;
    drop_d    = drop_q;
    if (xfer) begin
      ptr_d   = sel;
      grant_d = 2'(sel);
      if (sel_addr != '0) begin
        wr_en_d   = 1'b1;
        wr_addr_d = sel_addr;
        wr_data_d = sel_data;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  // State registers; reset leaves requester 0 with first priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q     <= PTR_W'(NUM_REQ - 1);
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      grant_q   <= '0;
      drop_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      grant_q   <= grant_d;
      drop_q    <= drop_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign grant_id = grant_q;
  assign drop_cnt = drop_q;

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 3, giving the number of writeback requesters (legal range 2..4).
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the register data width.
REQ-003 The block SHALL have parameter ADDR_W, default 5, giving the register index width.
REQ-004 The block SHALL have port clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port wb_stall  input  1  register-file-side hold; when high, no request is accepted.
REQ-007 The block SHALL have port req_valid  input  NUM_REQ  per-requester write request.
REQ-008 The block SHALL have port req_addr  input  NUM_REQ*ADDR_W  destination index; requester i occupies bits [i*ADDR_W +: ADDR_W].
REQ-009 The block SHALL have port req_data  input  NUM_REQ*DATA_W  write data; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-010 The block SHALL have port req_ready  output  NUM_REQ  one-hot or zero acceptance, combinational.
REQ-011 The block SHALL have port wr_en  output  1  registered write enable to the register.
REQ-012 The block SHALL have port wr_addr  output  ADDR_W  registered write index.
REQ-013 The block SHALL have port wr_data  output  DATA_W  registered write data.
REQ-014 The block SHALL have port grant_id  output  2  registered index of the last accepted requester.
REQ-015 The block SHALL have port drop_cnt  output  8  saturating count of accepted writes to index 0.

Function
REQ-016 A transfer on requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both high.
REQ-017 req_ready SHALL be all-zero when wb_stall is high or when no req_valid bit is high.
REQ-018 Otherwise exactly one req_ready bit SHALL be high: the first valid requester searching upward, with wrap-around, from index ptr+1.
REQ-019 The round-robin pointer ptr SHALL load the accepted index on each transfer and SHALL hold otherwise.
REQ-020 A requester holding req_valid SHALL be granted within NUM_REQ transfer cycles (no starvation).
REQ-021 On a transfer with a nonzero address, wr_en SHALL be 1 in the following cycle, with wr_addr/wr_data equal to the accepted address and data (latency 1).
REQ-022 On a transfer with address 0, the request SHALL be accepted; wr_en SHALL be 0 next cycle; drop_cnt SHALL increment, saturating at 255.
REQ-023 In any cycle without a transfer, wr_en SHALL be 0 next cycle; wr_addr, wr_data and grant_id SHALL hold their values.
REQ-024 grant_id SHALL update to the accepted index on every transfer, including address-0 transfers.
REQ-025 A wb_stall rising edge SHALL NOT cancel a write already registered on wr_en; that write SHALL complete.
REQ-026 Requesters SHALL hold req_valid, req_addr and req_data stable until accepted; the bench SHALL flag any violation.

Reset
REQ-027 While reset is high, in the next cycle: wr_en=0, wr_addr=0, wr_data=0, grant_id=0, drop_cnt=0, and ptr=NUM_REQ-1, so that requester 0 has first priority.
REQ-028 req_ready SHALL be all-zero in any cycle where reset is high.
REQ-029 Reset asserted mid-stream SHALL discard any registered write (wr_en=0 next cycle) and SHALL clear the pointer; no transfer SHALL occur in the reset cycle.

Verification
REQ-030 After reset, req_valid=3'b111 with addrs 1/2/3 held for 3 cycles -> grants 0, 1, 2 in order; wr_en=1 in cycles 2-4 with wr_addr 1, 2, 3.
REQ-031 Requester 1 valid alone, addr=5, data=32'hDEADBEEF -> req_ready=3'b010 same cycle; next cycle wr_en=1, wr_addr=5, wr_data=32'hDEADBEEF, grant_id=1.
REQ-032 Requester 2 writes addr 0 three times -> each is accepted; wr_en stays 0; drop_cnt=3. Continuing for 300 writes -> drop_cnt=255.
REQ-033 wb_stall=1 with all requesters valid for 4 cycles -> req_ready=0 and wr_en=0 throughout; on release, the first grant goes to ptr+1.
REQ-034 Reset asserted in the cycle after a transfer to addr 7 -> wr_en=0 next cycle, grant_id=0, and the following grant goes to requester 0.
REQ-035 Random valid/stall traffic for 10k cycles -> each requester's writes are observed on wr_* in issue order; no requester waits more than NUM_REQ transfers.
